pwm_multi: RTL and testbench
============================

# pwm_multi

Multi-channel, parametrised PWM generator; successor to the single-channel 8-bit PWM. Adds per-channel duty, programmable period, clock prescaler, edge- or center-aligned counting, glitch-free shadowed updates at period boundaries, and a period-start sync pulse. It sits between control-register logic and output pins, e.g. motor or LED drivers.

## Interface
- WIDTH, 8, counter/duty/period width
- CH, 4, number of PWM channels
- PRESC_W, 4, prescaler width
- CLK  in  1  clock, rising edge
- aRSTin  in  1  asynchronous active-low reset
- EN  in  1  run enable
- MODE  in  1  0 = edge-aligned (up), 1 = center-aligned (up/down); shadowed
- PRESC  in  PRESC_W  counter advances once per PRESC+1 clocks; live, not shadowed
- PERIOD  in  WIDTH  top count P; shadowed
- Din  in  CH*WIDTH  duty per channel, channel i at bits [i*WIDTH +: WIDTH]; shadowed
- WR  in  1  one-cycle strobe capturing Din, PERIOD and MODE into the shadow set
- PWM  out  CH  PWM outputs, registered
- SYNC  out  1  one-cycle pulse in the first cycle of each period
- PENDING  out  1  shadow set written but not yet applied

## Operation
- Registers: prescaler pc, counter cnt, direction dir (UP/DOWN), active set (Dact[i], Pact, Mact), shadow set, pending flag.
- Reset (aRSTin=0, asynchronous): pc=0, cnt=0, dir=UP, Dact and shadow duties=0, Pact and shadow period=all ones, Mact=0, PWM=0, SYNC=0, PENDING=0.
- EN=0: pc=0, cnt=0, dir=UP, PWM=0, SYNC=0. WR is still accepted into the shadow set.
- First enabled cycle after EN=0 or reset counts as a boundary: cnt=0, pending set applied, SYNC=1.
- Tick: asserted when pc >= PRESC. On a tick, pc←0 and cnt steps; otherwise pc←pc+1. Using >= makes a live reduction of PRESC safe.
- Edge mode: cnt runs 0..Pact, then wraps to 0. The boundary is the wrap. The period is (Pact+1)·(PRESC+1) clocks.
- Center mode: cnt runs 0..Pact with dir=UP, then Pact-1..1 with dir=DOWN, then back to 0. The boundary is the return to 0. The period is 2·Pact·(PRESC+1) clocks.
- Pact=0 (either mode): cnt stays at 0 and every tick is a boundary.
- Compare: PWM[i] = (cnt < Dact[i]), unsigned, WIDTH bits, using the cnt and Dact values valid in the same cycle. Compute it from next-state values so the output stays registered.
- Duty 0 gives constant low. Any Dact[i] > Pact gives constant high.
- Update: WR writes the shadow set and sets PENDING=1. At a boundary, the active set is loaded from the shadow set, PENDING←0 and dir←UP. If several WRs arrive before a boundary, the last one wins.
- WR in the same cycle as a boundary: the new data is applied at that boundary and PENDING stays 0.
- A MODE change takes effect only at a boundary; the new period starts at cnt=0 with dir=UP.

## Timing
- Every output is a flop; there are no combinational paths from any input to any output.
- SYNC is high in exactly the cycle in which cnt becomes 0 at a boundary, on the tick edge. It lasts one clock regardless of PRESC.
- PENDING rises the cycle after WR and falls the cycle after the applying boundary.
- aRSTin assertion clears outputs immediately, without a clock. After release, outputs stay 0 until the first enabled clock edge.
- Reset mid-period discards the shadow set and any pending update.

## Test plan
- Reset, then PRESC=0, MODE=0, WR with PERIOD=255 and Din={255,128,64,0} (ch3..ch0), EN=1 → ch0 always low; ch1, ch2, ch3 high for 64, 128 and 255 of every 256 cycles; SYNC every 256 cycles.
- Run the setup above, then WR ch0 duty=32 while cnt=100 → PENDING=1, ch0 unchanged until the wrap; from the next SYNC, ch0 is high 32 of 256 cycles and PENDING=0.
- MODE=1, PERIOD=10, ch0 duty=4, PRESC=0 → period 20 clocks, SYNC every 20, ch0 high 7 consecutive cycles per period (cnt 0..3 up, 3..1 down).
- MODE=0, PRESC=3, PERIOD=9, ch0 duty=5 → period 40 clocks, ch0 high 20 then low 20, SYNC one clock wide.
- PERIOD=99, ch0 duty=200, ch1 duty=0 → ch0 constant high, ch1 constant low. WR coincident with SYNC → applied at once, PENDING never rises.
- Pull aRSTin low asynchronously mid-period with PENDING=1 → PWM=0, SYNC=0, PENDING=0 before the next edge. After release with EN=1, first cycle shows SYNC=1, cnt=0 and duties 0.

Source files
------------

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with prescaler, edge/center-aligned counting,
// shadowed duty/period/mode updates applied at period boundaries, and a sync pulse.
module pwm_multi #(
  parameter int WIDTH   = 8,
  parameter int CH      = 4,
  parameter int PRESC_W = 4
) (
  input  logic                  CLK,
  input  logic                  aRSTin,
  input  logic                  EN,
  input  logic                  MODE,
  input  logic [PRESC_W-1:0]    PRESC,
  input  logic [WIDTH-1:0]      PERIOD,
  input  logic [CH*WIDTH-1:0]   Din,
  input  logic                  WR,
  output logic [CH-1:0]         PWM,
  output logic                  SYNC,
  output logic                  PENDING
);

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  logic [PRESC_W-1:0]  pc, pc_n;
  logic [WIDTH-1:0]    cnt, cnt_n;
  dir_t                dir, dir_n;
  logic [CH*WIDTH-1:0] dact, dact_n, sh_d;
  logic [WIDTH-1:0]    pact, pact_n, sh_p;
  logic                mact, mact_n, sh_m;
  logic                running;
  logic                tick, bnd;
  logic [CH-1:0]       pwm_n;
  logic                pending_n;

  assign tick = (pc >= PRESC);

  // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latches).
  always_comb begin
    pc_n   = pc;
    cnt_n  = cnt;
    dir_n  = dir;
    dact_n = dact;
    pact_n = pact;
    mact_n = mact;
    bnd    = 1'b0;
    if (!EN) begin
      pc_n  = '0;
      cnt_n = '0;
      dir_n = UP;
    end else if (!running) begin
      // Restart after disable or reset is treated as a period boundary.
      bnd  = 1'b1;
      pc_n = '0;
    end else if (!tick) begin
      pc_n = pc + 1'b1;
    end else begin
      pc_n = '0;
      if (!mact) begin
        if (cnt >= pact) bnd = 1'b1;
        else             cnt_n = cnt + 1'b1;
      end else if (dir == UP) begin
        if (cnt >= pact) begin
          if (pact <= WIDTH'(1)) bnd = 1'b1;
          else begin
            dir_n = DOWN;
            cnt_n = pact - 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end else begin
        if (cnt <= WIDTH'(1)) bnd = 1'b1;
        else                  cnt_n = cnt - 1'b1;
      end
    end
    if (bnd) begin
      cnt_n = '0;
      dir_n = UP;
      // A write landing on the boundary bypasses the shadow and applies at once.
      if (WR) begin
        dact_n = Din;
        pact_n = PERIOD;
        mact_n = MODE;
      end else if (PENDING) begin
        dact_n = sh_d;
        pact_n = sh_p;
        mact_n = sh_m;
      end
    end
  end

  // Compare against next-state values so the registered output matches cnt in the same cycle.
  always_comb begin
    pwm_n = '0;
    for (int i = 0; i < CH; i++)
      pwm_n[i] = EN && (cnt_n < dact_n[i*WIDTH +: WIDTH]);
  end

  assign pending_n = bnd ? 1'b0 : (WR ? 1'b1 : PENDING);

  // NOTE: sequential state uses non-blocking assignments only, so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge aRSTin) begin
    if (!aRSTin) begin
      pc      <= '0;
      cnt     <= '0;
      dir     <= UP;
      dact    <= '0;
      pact    <= '1;
      mact    <= 1'b0;
      sh_d    <= '0;
      sh_p    <= '1;
      sh_m    <= 1'b0;
      running <= 1'b0;
      PWM     <= '0;
      SYNC    <= 1'b0;
      PENDING <= 1'b0;
    end else begin
      pc      <= pc_n;
      cnt     <= cnt_n;
      dir     <= dir_n;
      dact    <= dact_n;
      pact    <= pact_n;
      mact    <= mact_n;
      running <= EN;
      PWM     <= pwm_n;
      SYNC    <= bnd;
      PENDING <= pending_n;
      if (WR) begin
        sh_d <= Din;
        sh_p <= PERIOD;
        sh_m <= MODE;
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed self-checking bench for pwm_multi: edge/center modes, prescaler,
// shadowed updates, saturated duties and asynchronous reset.
module tb_pwm_multi;

  localparam int WIDTH   = 8;
  localparam int CH      = 4;
  localparam int PRESC_W = 4;

  logic                CLK = 1'b0;
  logic                aRSTin;
  logic                EN;
  logic                MODE;
  logic [PRESC_W-1:0]  PRESC;
  logic [WIDTH-1:0]    PERIOD;
  logic [CH*WIDTH-1:0] Din;
  logic                WR;
  logic [CH-1:0]       PWM;
  logic                SYNC;
  logic                PENDING;

  int checks = 0;
  int errors = 0;

  int          hi [CH];
  int          syncs;
  int          pends;
  logic [63:0] pat;

  pwm_multi #(.WIDTH(WIDTH), .CH(CH), .PRESC_W(PRESC_W)) dut (
    .CLK     (CLK),
    .aRSTin  (aRSTin),
    .EN      (EN),
    .MODE    (MODE),
    .PRESC   (PRESC),
    .PERIOD  (PERIOD),
    .Din     (Din),
    .WR      (WR),
    .PWM     (PWM),
    .SYNC    (SYNC),
    .PENDING (PENDING)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Accumulate per-channel high counts, sync/pending counts and the ch0 pattern over n cycles.
  task automatic measure(input int n);
    for (int c = 0; c < CH; c++) hi[c] = 0;
    syncs = 0;
    pends = 0;
    pat   = '0;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < CH; c++) hi[c] += int'(PWM[c]);
      syncs += int'(SYNC);
      pends += int'(PENDING);
      if (i < 64) pat[i] = PWM[0];
      step();
    end
  endtask

  task automatic write_cfg(input logic m, input logic [WIDTH-1:0] p, input logic [CH*WIDTH-1:0] d);
    MODE   = m;
    PERIOD = p;
    Din    = d;
    WR     = 1'b1;
    step();
    WR     = 1'b0;
  endtask

  task automatic restart();
    EN = 1'b0;
    step();
    check("disabled_pwm", PWM, 4'b0000);
    check("disabled_sync", SYNC, 1'b0);
    EN = 1'b1;
    step();
  endtask

  initial begin
    aRSTin = 1'b0;
    EN     = 1'b0;
    MODE   = 1'b0;
    PRESC  = '0;
    PERIOD = '0;
    Din    = '0;
    WR     = 1'b0;
    #1;
    check("reset_pwm", PWM, 4'b0000);
    check("reset_sync", SYNC, 1'b0);
    check("reset_pending", PENDING, 1'b0);
    step();
    aRSTin = 1'b1;

    // Edge mode, period 256, duties {255,128,64,0}
    write_cfg(1'b0, 8'd255, {8'd255, 8'd128, 8'd64, 8'd0});
    check("t1_pending_set", PENDING, 1'b1);
    EN = 1'b1;
    step();
    check("t1_first_sync", SYNC, 1'b1);
    check("t1_pending_clr", PENDING, 1'b0);
    check("t1_first_pwm", PWM, 4'b1110);
    measure(256);
    check("t1_ch0_hi", hi[0], 0);
    check("t1_ch1_hi", hi[1], 64);
    check("t1_ch2_hi", hi[2], 128);
    check("t1_ch3_hi", hi[3], 255);
    check("t1_syncs", syncs, 1);
    check("t1_next_sync", SYNC, 1'b1);

    // Shadowed update of ch0 mid-period (cnt=100)
    measure(100);
    write_cfg(1'b0, 8'd255, {8'd255, 8'd128, 8'd64, 8'd32});
    check("t2_pending_set", PENDING, 1'b1);
    measure(155);
    check("t2_ch0_old_duty", hi[0], 0);
    check("t2_pending_held", pends, 155);
    check("t2_wrap_sync", SYNC, 1'b1);
    check("t2_pending_clr", PENDING, 1'b0);
    measure(256);
    check("t2_ch0_hi", hi[0], 32);
    check("t2_ch1_hi", hi[1], 64);
    check("t2_syncs", syncs, 1);

    // Center mode, PERIOD=10, ch0 duty=4
    write_cfg(1'b1, 8'd10, {8'd0, 8'd0, 8'd0, 8'd4});
    check("t3_pending_set", PENDING, 1'b1);
    restart();
    check("t3_sync", SYNC, 1'b1);
    check("t3_pending_clr", PENDING, 1'b0);
    measure(20);
    check("t3_ch0_pattern", pat, 64'h0000_0000_000E_000F);
    check("t3_ch0_hi", hi[0], 7);
    check("t3_syncs", syncs, 1);
    check("t3_next_sync", SYNC, 1'b1);

    // Edge mode with prescaler 3, PERIOD=9, ch0 duty=5
    PRESC = 4'd3;
    write_cfg(1'b0, 8'd9, {8'd0, 8'd0, 8'd0, 8'd5});
    restart();
    check("t4_sync", SYNC, 1'b1);
    measure(40);
    check("t4_ch0_pattern", pat, 64'h0000_0000_000F_FFFF);
    check("t4_syncs", syncs, 1);
    check("t4_next_sync", SYNC, 1'b1);
    step();
    check("t4_sync_width", SYNC, 1'b0);

    // Saturated duties, then WR coincident with the boundary
    PRESC = 4'd0;
    write_cfg(1'b0, 8'd99, {8'd0, 8'd0, 8'd0, 8'd200});
    restart();
    measure(99);
    check("t5_ch0_const_hi", hi[0], 99);
    check("t5_ch1_const_lo", hi[1], 0);
    write_cfg(1'b0, 8'd99, {8'd0, 8'd0, 8'd200, 8'd0});
    check("t5_coinc_sync", SYNC, 1'b1);
    check("t5_coinc_pending", PENDING, 1'b0);
    check("t5_coinc_pwm", PWM, 4'b0010);
    measure(20);
    check("t5_pending_never", pends, 0);
    check("t5_ch1_hi", hi[1], 20);
    check("t5_ch0_hi", hi[0], 0);

    // Asynchronous reset with an update pending
    write_cfg(1'b0, 8'd99, {8'd0, 8'd0, 8'd0, 8'd50});
    check("t6_pending_set", PENDING, 1'b1);
    #2;
    aRSTin = 1'b0;
    #1;
    check("t6_async_pwm", PWM, 4'b0000);
    check("t6_async_sync", SYNC, 1'b0);
    check("t6_async_pending", PENDING, 1'b0);
    #2;
    aRSTin = 1'b1;
    step();
    check("t6_first_sync", SYNC, 1'b1);
    check("t6_first_pwm", PWM, 4'b0000);
    check("t6_first_pending", PENDING, 1'b0);
    measure(30);
    check("t6_duties_zero", hi[0] + hi[1] + hi[2] + hi[3], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
